serial_addsub: RTL

//  Bit-serial two's-complement adder/subtractor with a parametrised operand width.

---
 rtl/serial_addsub.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice and a carry flop,
// LSB first, WIDTH steps per operation with a start/busy/done handshake.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [WIDTH-1:0] res_nxt;
   logic [CW-1:0]    count;
   logic             carry;
   logic             fa_s;
   logic             fa_c;
   logic             c_msb_in;
   logic             last_step;

   // The single full-adder slice.
   assign fa_s      = a_reg[0] ^ b_reg[0] ^ carry;
   assign fa_c      = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
   assign res_nxt   = {fa_s, res_reg[WIDTH-1:1]};
   assign last_step = (state == SHIFT) && (count == LAST);
   // During the final step the carry flop holds the carry into the MSB.
   assign c_msb_in  = carry;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // NOTE: state and datapath flops use non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (count == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every datapath register, including the shift registers, is cleared by
   // reset so an aborted operation leaves no stale result visible.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         carry   <= 1'b0;
         count   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                  a_reg   <= a;
                  b_reg   <= b ^ {WIDTH{sub}};
                  carry   <= sub;
                  count   <= '0;
                  res_reg <= '0;
               end
            end
            SHIFT: begin
               a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
               b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
               res_reg <= res_nxt;
               carry   <= fa_c;
               count   <= count + CW'(1);
               if (last_step) begin
                  sum  <= res_nxt;
                  cout <= fa_c;
                  ovf  <= c_msb_in ^ fa_c;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
